// File: rtl/parity_frame_tx.sv
// -----------------------------------------------------------------------------
// parity_frame_tx
//
// Serial frame transmitter for a 4-bit nibble and its even parity bit.
// The line carries: start (0), b[0], b[1], b[2], b[3], parity, stop (1).
// Each bit is held for CLKS_PER_BIT clock cycles. tx comes from a register.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (1..255), default 4
//
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  asynchronous active-high reset
//   b     in  4  data nibble
//   p     in  1  even parity bit for b
//   start in  1  transmit request, sampled only while ready=1
//   ready out 1  idle and able to accept
//   tx    out 1  serial line, idles high
//   done  out 1  one-cycle pulse as the stop bit completes
//   perr  out 1  parity mismatch pulse (checker only)
//
// Optional feature: define PARITY_FRAME_CHECK_EN to recompute ^b at accept.
// A mismatch with p pulses perr for one cycle and the recomputed parity is
// sent instead of p. Without the macro, perr is tied to 0 and p is sent as is.
// -----------------------------------------------------------------------------
module parity_frame_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] b,
   input  logic       p,
   input  logic       start,
   output logic       ready,
   output logic       tx,
   output logic       done,
   output logic       perr
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [1:0]    idx_reg, idx_next;
   logic [3:0]    shift_reg, shift_next;
   logic          par_reg, par_next;
   logic          tx_reg, tx_next;
   logic          done_reg, done_next;
   logic          bit_end;
   logic          par_load;

`ifdef PARITY_FRAME_CHECK_EN
   logic          perr_reg, perr_next;
   logic          mismatch;

   // The line always carries correct even parity, whatever p says.
   assign mismatch = (^b) != p;
   assign par_load = ^b;
`else
   assign par_load = p;
`endif

   assign bit_end = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         tx_reg    <= 1'b1;
         done_reg  <= 1'b0;
`ifdef PARITY_FRAME_CHECK_EN
         perr_reg  <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         tx_reg    <= tx_next;
         done_reg  <= done_next;
`ifdef PARITY_FRAME_CHECK_EN
         perr_reg  <= perr_next;
`endif
      end
   end

   // tx_next is the value the line will carry in the cycle after this edge,
   // so every transition loads the first level of the state being entered.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      par_next   = par_reg;
      tx_next    = tx_reg;
      done_next  = 1'b0;
`ifdef PARITY_FRAME_CHECK_EN
      perr_next  = 1'b0;
`endif

      // Bit-time counter runs in every non-idle state.
      if (state_reg != IDLE) begin
         cnt_next = bit_end ? '0 : cnt_reg + CW'(1);
      end

      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (start) begin
               shift_next = b;
               par_next   = par_load;
               cnt_next   = '0;
               idx_next   = '0;
               tx_next    = 1'b0;
               state_next = START;
`ifdef PARITY_FRAME_CHECK_EN
               perr_next  = mismatch;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               tx_next    = shift_reg[0];
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_reg == 2'd3) begin
                  tx_next    = par_reg;
                  state_next = PARITY;
               end else begin
                  // Bit 1 becomes bit 0 after the shift.
                  tx_next    = shift_reg[1];
                  shift_next = shift_reg >> 1;
                  idx_next   = idx_reg + 2'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   assign ready = (state_reg == IDLE);
   assign tx    = tx_reg;
   assign done  = done_reg;
`ifdef PARITY_FRAME_CHECK_EN
   assign perr  = perr_reg;
`else
   assign perr  = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_tx
//
// Drives two parity_frame_tx instances (CLKS_PER_BIT = 4 and 1) from shared
// inputs. A frame-level reference model per instance tracks how many cycles
// of the current frame remain and which 7-bit frame is on the line; the
// expected tx level is the frame bit selected by elapsed_cycles / cpb.
// -----------------------------------------------------------------------------
module tb_parity_frame_tx;

   logic       clk;
   logic       rst;
   logic [3:0] b;
   logic       p;
   logic       start;
   logic       ready_o [2];
   logic       tx_o    [2];
   logic       done_o  [2];
   logic       perr_o  [2];

   int n_checks;
   int n_fail;

   // reference model state
   int       cpb_tab [2] = '{4, 1};
   int       rem     [2];
   bit [6:0] frm     [2];
   bit       done_e  [2];
   bit       perr_e  [2];
   int       done_cnt [2];

   parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .b(b), .p(p), .start(start),
      .ready(ready_o[0]), .tx(tx_o[0]), .done(done_o[0]), .perr(perr_o[0])
   );

   parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .b(b), .p(p), .start(start),
      .ready(ready_o[1]), .tx(tx_o[1]), .done(done_o[1]), .perr(perr_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // One clock edge of the frame-level model for instance k.
   task automatic model_step(input int k, input logic rs, input logic [3:0] bs,
                             input logic ps, input logic ss);
      bit par;
      done_e[k] = 1'b0;
      perr_e[k] = 1'b0;
      if (rs) begin
         rem[k] = 0;
      end else if (rem[k] > 0) begin
         rem[k]--;
         if (rem[k] == 0) done_e[k] = 1'b1;
      end else if (ss) begin
         par = ps;
`ifdef PARITY_FRAME_CHECK_EN
         par = ^bs;
         perr_e[k] = (^bs) != ps;
`endif
         frm[k] = {1'b1, par, bs, 1'b0};
         rem[k] = 7 * cpb_tab[k];
      end
   endtask

   function automatic bit exp_tx(input int k);
      int elapsed;
      if (rem[k] == 0) return 1'b1;
      elapsed = 7 * cpb_tab[k] - rem[k];
      return frm[k][elapsed / cpb_tab[k]];
   endfunction

   // Advance one clock, update models from the inputs seen at the edge,
   // then compare every output of both instances.
   task automatic tick();
      logic [3:0] bs;
      logic ps, ss, rs;
      bs = b; ps = p; ss = start; rs = rst;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         model_step(k, rs, bs, ps, ss);
         check($sformatf("tx[%0d]", k),    32'(tx_o[k]),    32'(exp_tx(k)));
         check($sformatf("ready[%0d]", k), 32'(ready_o[k]), 32'(rem[k] == 0));
         check($sformatf("done[%0d]", k),  32'(done_o[k]),  32'(done_e[k]));
         check($sformatf("perr[%0d]", k),  32'(perr_o[k]),  32'(perr_e[k]));
         if (done_o[k] === 1'b1) done_cnt[k]++;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int accept_t;
      n_checks = 0;
      n_fail   = 0;
      for (int k = 0; k < 2; k++) begin
         rem[k] = 0; frm[k] = '0; done_cnt[k] = 0;
      end
      rst = 1'b1; b = 4'h0; p = 1'b0; start = 1'b0;

      // reset state
      ticks(2);
      rst = 1'b0;
      ticks(2);

      // single frame b=0110 p=0; line 0,0,1,1,0,0,1 at 4 cycles per bit
      b = 4'b0110; p = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      b = 4'hF; p = 1'b1;
      accept_t = 0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (done_o[0] === 1'b1 && accept_t == 0) accept_t = i;
      end
      check("done_latency4", 32'(accept_t), 32'd28);

      // sweep for CPB=1: 16 back-to-back-paced frames
      done_cnt[1] = 0;
      for (int v = 0; v < 16; v++) begin
         logic [3:0] nv;
         nv = 4'(v);
         b = nv; p = ^nv; start = 1'b1;
         tick();
         start = 1'b0;
         ticks(7);
      end
      check("sweep_done_count", 32'(done_cnt[1]), 32'd16);
      ticks(30);

      // busy ignore + back-to-back: start held, b changes mid-frame
      b = 4'b1011; p = 1'b1; start = 1'b1;
      ticks(10);
      b = 4'b0000; p = 1'b0;
      ticks(50);
      start = 1'b0;
      ticks(30);

      // parity mismatch stimulus: b=0111 p=0
      b = 4'b0111; p = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      ticks(30);

      // asynchronous reset mid-frame
      b = 4'b1001; p = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      ticks(5);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("async_tx[%0d]", k),    32'(tx_o[k]),    32'd1);
         check($sformatf("async_ready[%0d]", k), 32'(ready_o[k]), 32'd1);
      end
      ticks(2);
      rst = 1'b0;
      b = 4'b0101; p = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      ticks(30);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         b     = 4'($urandom_range(0, 15));
         p     = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 3) == 0);
         tick();
      end
      start = 1'b0;
      ticks(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
